// File: rtl/fetch_queue_pkg.sv
// Shared constants and helpers for the instruction fetch stage: reset PC, canonical NOP,
// and the FIFO operation encoding used by the prefetch buffer.
package fetch_queue_pkg;

    localparam int unsigned DATAW_DEF     = 32;
    localparam logic [31:0] BASE_ADDR_DEF = 32'h0100_0000;
    localparam logic [6:0]  OPC_OP_IMM    = 7'b001_0011;
    // ADDI x0, x0, 0
    localparam logic [31:0] NOP_INSTR_DEF = {12'h000, 5'd0, 3'b000, 5'd0, OPC_OP_IMM};

    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_PUSH = 2'b01,
        FIFO_POP  = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e fifo_op(input logic push, input logic pop);
        return fifo_op_e'({pop, push});
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH entries of {pc, instr}, naturally wrapping pointers with a
// separate count so full and empty are distinguishable; flush empties it in one edge.
module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTRW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTRW-1:0]  wr_ptr;
    logic [PTRW-1:0]  rd_ptr;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            case (fifo_op(push, pop))
                FIFO_PUSH: begin
                    wr_ptr <= wr_ptr + 1'b1;
                    count  <= count + 1'b1;
                end
                FIFO_POP: begin
                    rd_ptr <= rd_ptr + 1'b1;
                    count  <= count - 1'b1;
                end
                FIFO_BOTH: begin
                    wr_ptr <= wr_ptr + 1'b1;
                    rd_ptr <= rd_ptr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count gates every read, so stale contents are never seen.
    always_ff @(posedge clock) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited sequential fetches,
// buffers returned {pc, instr} pairs and hands them to decode; redirects flush everything.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int               DATAW     = 32,
    parameter logic [DATAW-1:0] BASE_ADDR = DATAW'(BASE_ADDR_DEF),
    parameter int               DEPTH     = 4,
    parameter logic [DATAW-1:0] NOP_INSTR = DATAW'(NOP_INSTR_DEF)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       redirect_valid,
    input  logic [DATAW-1:0]           redirect_pc,
    output logic                       imem_req,
    output logic [DATAW-1:0]           imem_addr,
    input  logic [DATAW-1:0]           imem_rdata,
    input  logic                       imem_rvalid,
    output logic                       fd_valid,
    input  logic                       fd_ready,
    output logic [DATAW-1:0]           fd_pc,
    output logic [DATAW-1:0]           fd_instr,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int CNTW = $clog2(DEPTH+1);

    logic [DATAW-1:0]   fetch_pc;
    logic [DATAW-1:0]   inflight_pc;
    logic               outstanding;
    logic [CNTW:0]      committed;
    logic               credit_ok;
    logic               push;
    logic               pop;
    logic [2*DATAW-1:0] head_data;
    logic [DATAW-1:0]   head_pc;
    logic [DATAW-1:0]   head_instr;
    logic               unused_redirect_lo;

    // A slot is committed once requested, so an in-flight fetch counts against capacity.
    assign committed = (CNTW+1)'(occupancy) + (CNTW+1)'(outstanding);
    assign credit_ok = committed < (CNTW+1)'(DEPTH);

    // Gating with reset keeps the request low for the whole reset interval, not just after an edge.
    assign imem_req  = reset && !redirect_valid && credit_ok;
    assign imem_addr = fetch_pc;

    assign push = imem_rvalid && !redirect_valid;
    assign pop  = fd_valid && fd_ready && !redirect_valid;

    // Redirect targets are word aligned by dropping the low bits.
    assign unused_redirect_lo = ^redirect_pc[1:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= BASE_ADDR;
            inflight_pc <= '0;
            outstanding <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc    <= {redirect_pc[DATAW-1:2], 2'b00};
            outstanding <= 1'b0;
        end else if (imem_req) begin
            fetch_pc    <= fetch_pc + DATAW'(4);
            inflight_pc <= fetch_pc;
            outstanding <= 1'b1;
        end else begin
            outstanding <= 1'b0;
        end
    end

    fetch_fifo #(
        .WIDTH (2*DATAW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ({inflight_pc, imem_rdata}),
        .pop       (pop),
        .head_data (head_data),
        .count     (occupancy)
    );

    assign {head_pc, head_instr} = head_data;
    assign fd_valid = (occupancy != '0);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        fd_pc    = '0;
        fd_instr = NOP_INSTR;
        if (fd_valid) begin
            fd_pc    = head_pc;
            fd_instr = head_instr;
        end
    end

    a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
        !(push && !pop && occupancy == CNTW'(DEPTH)));

endmodule
